// File: rtl/arm_fetch_decode_front.sv
// rtl/arm_fetch_decode_front.sv - ARM pipeline fetch stage, IF/ID register and instruction decode
module arm_fetch_decode_front #(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic [3:0]  status,
    input  logic        wb_we,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic [31:0] pc_if,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [3:0]  alu_cmd,
    output logic [3:0]  dest,
    output logic        status_en,
    output logic        mem_read,
    output logic        mem_write,
    output logic        wb_en,
    output logic        branch,
    output logic        imm,
    output logic [23:0] b_signed_imm,
    output logic [11:0] shifter_operand
);

    logic [31:0] pc;
    logic [31:0] rf [0:14];

    assign imem_addr = pc;
    assign pc_if     = pc + 32'(PC_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= PC_RESET;
        end else if (branch_taken) begin
            pc <= branch_addr;
        end else if (!hazard) begin
            pc <= pc_if;
        end
    end

    // A taken branch squashes the instruction fetched down the wrong path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_id    <= 32'h0;
            instr_id <= 32'h0;
        end else if (branch_taken) begin
            pc_id    <= 32'h0;
            instr_id <= 32'h0;
        end else if (!hazard) begin
            pc_id    <= pc_if;
            instr_id <= imem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 15; i++) begin
                rf[i] <= 32'(i);
            end
        end else if (wb_we && wb_dest != 4'hF) begin
            rf[wb_dest] <= wb_value;
        end
    end

    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] cond;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;

    assign cond            = instr_id[31:28];
    assign mode            = instr_id[27:26];
    assign imm             = instr_id[25];
    assign opcode          = instr_id[24:21];
    assign s_bit           = instr_id[20];
    assign rn              = instr_id[19:16];
    assign rd              = instr_id[15:12];
    assign rm              = instr_id[3:0];
    assign b_signed_imm    = instr_id[23:0];
    assign shifter_operand = instr_id[11:0];

    logic [3:0] cmd_raw;
    logic       sten_raw;
    logic       mr_raw;
    logic       mw_raw;
    logic       wb_raw;
    logic       br_raw;

    always_comb begin
        cmd_raw  = 4'b0000;
        sten_raw = 1'b0;
        mr_raw   = 1'b0;
        mw_raw   = 1'b0;
        wb_raw   = 1'b0;
        br_raw   = 1'b0;
        case (mode)
            2'b00: begin
                case (opcode)
                    4'b1101: begin cmd_raw = 4'b0001; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b1111: begin cmd_raw = 4'b1001; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b0100: begin cmd_raw = 4'b0010; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b0101: begin cmd_raw = 4'b0011; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b0010: begin cmd_raw = 4'b0100; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b0110: begin cmd_raw = 4'b0101; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b0000: begin cmd_raw = 4'b0110; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b1100: begin cmd_raw = 4'b0111; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b0001: begin cmd_raw = 4'b1000; wb_raw = 1'b1; sten_raw = s_bit; end
                    4'b1010: begin cmd_raw = 4'b0100; sten_raw = s_bit; end
                    4'b1000: begin cmd_raw = 4'b0110; sten_raw = s_bit; end
                    default: ;
                endcase
            end
            2'b01: begin
                cmd_raw = 4'b0010;
                if (s_bit) begin
                    mr_raw = 1'b1;
                    wb_raw = 1'b1;
                end else begin
                    mw_raw = 1'b1;
                end
            end
            2'b10: begin
                br_raw = 1'b1;
            end
            default: ;
        endcase
    end

    logic n_f, z_f, c_f, v_f;
    logic cond_ok;

    assign {n_f, z_f, c_f, v_f} = status;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = z_f;
            4'h1: cond_ok = !z_f;
            4'h2: cond_ok = c_f;
            4'h3: cond_ok = !c_f;
            4'h4: cond_ok = n_f;
            4'h5: cond_ok = !n_f;
            4'h6: cond_ok = v_f;
            4'h7: cond_ok = !v_f;
            4'h8: cond_ok = c_f && !z_f;
            4'h9: cond_ok = !c_f || z_f;
            4'hA: cond_ok = (n_f == v_f);
            4'hB: cond_ok = (n_f != v_f);
            4'hC: cond_ok = !z_f && (n_f == v_f);
            4'hD: cond_ok = z_f || (n_f != v_f);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic issue;
    assign issue = cond_ok && !hazard;

    assign alu_cmd   = issue ? cmd_raw : 4'b0000;
    assign status_en = issue && sten_raw;
    assign mem_read  = issue && mr_raw;
    assign mem_write = issue && mw_raw;
    assign wb_en     = issue && wb_raw;
    assign branch    = issue && br_raw;

    // Operand indices follow the raw decode so hazard detection sees them even when bubbled.
    assign src1    = rn;
    assign src2    = mw_raw ? rd : rm;
    assign two_src = !imm || mw_raw;
    assign dest    = rd;

    always_comb begin
        reg1 = 32'h0;
        reg2 = 32'h0;
        if (src1 != 4'hF) begin
            reg1 = (wb_we && wb_dest == src1) ? wb_value : rf[src1];
        end
        if (src2 != 4'hF) begin
            reg2 = (wb_we && wb_dest == src2) ? wb_value : rf[src2];
        end
    end

endmodule

// File: tb/tb_arm_fetch_decode_front.sv
// tb/tb_arm_fetch_decode_front.sv - randomized self-checking bench for arm_fetch_decode_front
module tb_arm_fetch_decode_front;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [3:0]  status;
    logic        wb_we;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [31:0] pc_if, pc_id, instr_id, reg1, reg2;
    logic [3:0]  src1, src2, alu_cmd, dest;
    logic        two_src, status_en, mem_read, mem_write, wb_en, branch, imm;
    logic [23:0] b_signed_imm;
    logic [11:0] shifter_operand;

    arm_fetch_decode_front dut (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_data(imem_data),
        .status(status), .wb_we(wb_we), .wb_dest(wb_dest), .wb_value(wb_value),
        .pc_if(pc_if), .pc_id(pc_id), .instr_id(instr_id), .reg1(reg1), .reg2(reg2),
        .src1(src1), .src2(src2), .two_src(two_src), .alu_cmd(alu_cmd), .dest(dest),
        .status_en(status_en), .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en),
        .branch(branch), .imm(imm), .b_signed_imm(b_signed_imm), .shifter_operand(shifter_operand)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_pc_id, m_instr;
    logic [31:0] m_rf [15];

    typedef struct packed {
        logic [3:0] cmd;
        logic       sten, mr, mw, wb, br;
        logic [3:0] src2;
        logic       two;
    } dec_t;

    // Reference decode: mnemonic table lookup plus paired condition codes (odd code = negation).
    function automatic dec_t model_dec(input logic [31:0] ins, input logic [3:0] st, input logic hz);
        logic [3:0] ops  [11] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8};
        logic [3:0] cmds [11] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h4, 4'h6};
        dec_t d;
        logic n, z, c, v, ok;
        logic [7:0] base;
        d = '0;
        if (ins[27:26] == 2'd0) begin
            for (int k = 0; k < 11; k++) begin
                if (ops[k] == ins[24:21]) begin
                    d.cmd = cmds[k]; d.wb = (k < 9); d.sten = ins[20];
                end
            end
        end else if (ins[27:26] == 2'd1) begin
            d.cmd = 4'h2; d.mr = ins[20]; d.wb = ins[20]; d.mw = !ins[20];
        end else if (ins[27:26] == 2'd2) begin
            d.br = 1'b1;
        end
        d.src2 = d.mw ? ins[15:12] : ins[3:0];
        d.two  = !ins[25] || d.mw;
        {n, z, c, v} = st;
        base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
        ok = base[ins[31:29]] ^ ins[28];
        if (!ok || hz) begin
            d.cmd = 4'h0; d.sten = 1'b0; d.mr = 1'b0; d.mw = 1'b0; d.wb = 1'b0; d.br = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] idx);
        if (idx == 4'hF) return 32'h0;
        if (wb_we && wb_dest == idx) return wb_value;
        return m_rf[idx];
    endfunction

    // Advance model by one rising edge using the inputs currently applied.
    task automatic step();
        logic [31:0] npc, npcid, nins;
        npc = m_pc; npcid = m_pc_id; nins = m_instr;
        if (branch_taken) begin
            npc = branch_addr; npcid = 0; nins = 0;
        end else if (!hazard) begin
            npc = m_pc + 4; npcid = m_pc + 4; nins = imem_data;
        end
        if (wb_we && wb_dest != 4'hF) m_rf[wb_dest] = wb_value;
        @(posedge clk);
        #1;
        m_pc = npc; m_pc_id = npcid; m_instr = nins;
    endtask

    task automatic test_reset();
        rst = 1'b0; hazard = 0; branch_taken = 0; branch_addr = 0; imem_data = 0;
        status = 4'h0; wb_we = 0; wb_dest = 0; wb_value = 0;
        m_pc = 0; m_pc_id = 0; m_instr = 0;
        for (int i = 0; i < 15; i++) m_rf[i] = 32'(i);
        #23;
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", imem_addr); end
        n_cmp++; if (pc_id !== 32'h0) begin n_fail++; $display("FAIL reset_pc_id got %h exp 0", pc_id); end
        n_cmp++; if (instr_id !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr_id); end
        n_cmp++; if (pc_if !== 32'h4) begin n_fail++; $display("FAIL reset_pc_if got %h exp 4", pc_if); end
        n_cmp++; if ({alu_cmd, wb_en, mem_write, branch} !== 7'h0) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", {alu_cmd, wb_en, mem_write, branch}); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_fetch_seq();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL seq_addr got %h exp %h", imem_addr, m_pc); end
            w = $urandom;
            w[31:28] = 4'hE;
            imem_data = w;
            step();
            n_cmp++; if (imem_addr !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_addr_abs got %h exp %h", imem_addr, 4 * (i + 1)); end
            n_cmp++; if (pc_id !== m_pc_id) begin n_fail++; $display("FAIL seq_pc_id got %h exp %h", pc_id, m_pc_id); end
            n_cmp++; if (instr_id !== w) begin n_fail++; $display("FAIL seq_instr got %h exp %h", instr_id, w); end
            n_cmp++; if (reg1 !== mread(w[19:16])) begin n_fail++; $display("FAIL seq_reg1 got %h exp %h", reg1, mread(w[19:16])); end
        end
    endtask

    task automatic test_decode_random();
        dec_t e;
        for (int i = 0; i < 60; i++) begin
            hazard = 0;
            imem_data = $urandom;
            step();
            status = 4'($urandom);
            hazard = ($urandom_range(0, 3) == 0);
            wb_we = $urandom_range(0, 1);
            wb_dest = ($urandom_range(0, 1) == 0) ? m_instr[19:16] : 4'($urandom);
            wb_value = $urandom;
            #1;
            e = model_dec(m_instr, status, hazard);
            n_cmp++; if ({alu_cmd, status_en, mem_read, mem_write, wb_en, branch} !== {e.cmd, e.sten, e.mr, e.mw, e.wb, e.br})
                begin n_fail++; $display("FAIL rnd_ctrl ins %h st %h hz %b got %h exp %h", m_instr, status, hazard, {alu_cmd, status_en, mem_read, mem_write, wb_en, branch}, {e.cmd, e.sten, e.mr, e.mw, e.wb, e.br}); end
            n_cmp++; if ({src1, src2, two_src, dest} !== {m_instr[19:16], e.src2, e.two, m_instr[15:12]})
                begin n_fail++; $display("FAIL rnd_idx ins %h got %h exp %h", m_instr, {src1, src2, two_src, dest}, {m_instr[19:16], e.src2, e.two, m_instr[15:12]}); end
            n_cmp++; if ({imm, b_signed_imm, shifter_operand} !== {m_instr[25], m_instr[23:0], m_instr[11:0]})
                begin n_fail++; $display("FAIL rnd_imm got %h exp %h", {imm, b_signed_imm, shifter_operand}, {m_instr[25], m_instr[23:0], m_instr[11:0]}); end
            n_cmp++; if (reg1 !== mread(m_instr[19:16])) begin n_fail++; $display("FAIL rnd_reg1 got %h exp %h", reg1, mread(m_instr[19:16])); end
            n_cmp++; if (reg2 !== mread(e.src2)) begin n_fail++; $display("FAIL rnd_reg2 got %h exp %h", reg2, mread(e.src2)); end
        end
        hazard = 0; wb_we = 0;
    endtask

    task automatic test_mov();
        status = 4'h0;
        imem_data = 32'hE3A01005;
        step();
        n_cmp++; if ({alu_cmd, wb_en, imm, dest, shifter_operand, two_src} !== {4'h1, 1'b1, 1'b1, 4'h1, 12'h005, 1'b0})
            begin n_fail++; $display("FAIL mov_fields got %h exp %h", {alu_cmd, wb_en, imm, dest, shifter_operand, two_src}, {4'h1, 1'b1, 1'b1, 4'h1, 12'h005, 1'b0}); end
        imem_data = 32'h03A01005;
        step();
        n_cmp++; if ({alu_cmd, status_en, mem_read, mem_write, wb_en, branch} !== 9'h0)
            begin n_fail++; $display("FAIL mov_eq_false got %h exp 0", {alu_cmd, status_en, mem_read, mem_write, wb_en, branch}); end
    endtask

    task automatic test_hazard();
        logic [31:0] held_pc, held_ins;
        imem_data = 32'hE3A01005;
        step();
        held_pc = m_pc; held_ins = m_instr;
        hazard = 1;
        imem_data = 32'hE1A00000;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (imem_addr !== held_pc) begin n_fail++; $display("FAIL hz_pc got %h exp %h", imem_addr, held_pc); end
            n_cmp++; if (instr_id !== held_ins) begin n_fail++; $display("FAIL hz_instr got %h exp %h", instr_id, held_ins); end
            n_cmp++; if ({alu_cmd, wb_en} !== 5'h0) begin n_fail++; $display("FAIL hz_bubble got %h exp 0", {alu_cmd, wb_en}); end
        end
        hazard = 0;
        step();
        n_cmp++; if (imem_addr !== held_pc + 32'd4) begin n_fail++; $display("FAIL hz_resume got %h exp %h", imem_addr, held_pc + 32'd4); end
        n_cmp++; if (instr_id !== 32'hE1A00000) begin n_fail++; $display("FAIL hz_resume_instr got %h exp E1A00000", instr_id); end
    endtask

    task automatic test_branch();
        branch_taken = 1; branch_addr = 32'h40;
        step();
        n_cmp++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_addr got %h exp 40", imem_addr); end
        n_cmp++; if ({instr_id, pc_id} !== 64'h0) begin n_fail++; $display("FAIL br_flush got %h exp 0", {instr_id, pc_id}); end
        branch_taken = 0;
        step();
        branch_taken = 1; hazard = 1; branch_addr = 32'h80;
        step();
        n_cmp++; if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL br_hz_addr got %h exp 80", imem_addr); end
        n_cmp++; if (instr_id !== 32'h0) begin n_fail++; $display("FAIL br_hz_flush got %h exp 0", instr_id); end
        branch_taken = 0; hazard = 0;
    endtask

    task automatic test_writeback();
        imem_data = 32'hE2820000;
        step();
        wb_we = 1; wb_dest = 4'd2; wb_value = 32'hDEADBEEF;
        #1;
        n_cmp++; if (reg1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_through got %h exp deadbeef", reg1); end
        step();
        wb_we = 0;
        #1;
        n_cmp++; if (reg1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_stored got %h exp deadbeef", reg1); end
        imem_data = 32'hE28F0000;
        step();
        wb_we = 1; wb_dest = 4'hF; wb_value = 32'h12345678;
        #1;
        n_cmp++; if (reg1 !== 32'h0) begin n_fail++; $display("FAIL wb_r15_through got %h exp 0", reg1); end
        step();
        wb_we = 0;
        #1;
        n_cmp++; if (reg1 !== 32'h0) begin n_fail++; $display("FAIL wb_r15 got %h exp 0", reg1); end
    endtask

    task automatic test_str_cmp();
        status = 4'h0;
        imem_data = 32'hE5812000;
        step();
        n_cmp++; if ({mem_write, alu_cmd, src2, two_src, mem_read, wb_en} !== {1'b1, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL str got %h exp %h", {mem_write, alu_cmd, src2, two_src, mem_read, wb_en}, {1'b1, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0}); end
        n_cmp++; if (reg2 !== mread(4'd2)) begin n_fail++; $display("FAIL str_reg2 got %h exp %h", reg2, mread(4'd2)); end
        imem_data = 32'hE3510000;
        step();
        n_cmp++; if ({status_en, wb_en, alu_cmd} !== {1'b1, 1'b0, 4'h4})
            begin n_fail++; $display("FAIL cmp got %h exp %h", {status_en, wb_en, alu_cmd}, {1'b1, 1'b0, 4'h4}); end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_mov();
        test_hazard();
        test_branch();
        test_writeback();
        test_str_cmp();
        test_decode_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
